naughtyq_mc: RTL and testbench

- Multi-channel, parametrised successor to NaughtyQ: NUM_CHANNELS independent indexed circular queues sharing one register array, selected per command by chan_in.
- Keeps the enlist / read / back-of-queue command model and the sticky crash signal.
- Adds in-place data update, head dequeue, per-channel occupancy output and a multi-cycle back-of-queue shift.
- Sits between packet-handling logic and per-flow state, one channel per flow class.

---
 rtl/naughtyq_mc_if.sv | 28 ++
 rtl/naughtyq_mc.sv | 198 +++++++++++++++++++
 tb/tb_naughtyq_mc.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/naughtyq_mc_if.sv
// Command/response bundle for naughtyq_mc: the master issues queue commands,
// the slave (the queue) reports readiness, fault state and the last result.
interface naughtyq_mc_if #(
  parameter int IDX_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CHAN_WIDTH = 1
);
  logic [3:0]            command;
  logic                  enable;
  logic [CHAN_WIDTH-1:0] chan_in;
  logic [IDX_WIDTH-1:0]  idx_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  crashed;
  logic [IDX_WIDTH-1:0]  idx_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [IDX_WIDTH:0]    count_out;

  modport master (
    output command, enable, chan_in, idx_in, data_in,
    input  ready, crashed, idx_out, data_out, count_out
  );

  modport slave (
    input  command, enable, chan_in, idx_in, data_in,
    output ready, crashed, idx_out, data_out, count_out
  );
endinterface

// File: rtl/naughtyq_mc.sv
// Multi-channel indexed circular queues with in-place update, dequeue and a
// multi-cycle back-of-queue shift. Define NAUGHTYQ_MC_WRAP_EN to let ENLIST on a full channel overwrite the oldest entry.
module naughtyq_mc #(
  parameter int IDX_WIDTH    = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int CHAN_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic         clock,
  input  logic         reset,
  naughtyq_mc_if.slave bus
);

  // state    | meaning
  // ST_IDLE  | ready, accepts one command per enabled edge
  // ST_SHIFT | back-of-queue shift in progress, one slot per cycle
  // ST_CRASH | sticky fault, ignores commands until reset
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CRASH} state_t;

  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ENL   = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_WRITE = 4'd3;
  localparam logic [3:0] OP_BOQ   = 4'd4;
  localparam logic [3:0] OP_DEQ   = 4'd5;
  localparam logic [IDX_WIDTH-1:0] IDX_ONE    = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH:0]   CNT_ONE    = {{IDX_WIDTH{1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH:0]   FULL_COUNT = {1'b1, {IDX_WIDTH{1'b0}}};
`ifdef NAUGHTYQ_MC_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem   [NUM_CHANNELS][DEPTH];
  logic [IDX_WIDTH-1:0]  head  [NUM_CHANNELS];
  logic [IDX_WIDTH-1:0]  tail  [NUM_CHANNELS];
  logic [IDX_WIDTH:0]    count [NUM_CHANNELS];

  logic [IDX_WIDTH-1:0]  idx_out_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [IDX_WIDTH:0]    count_out_r;

  logic [CHAN_WIDTH-1:0] shift_ch;
  logic [IDX_WIDTH-1:0]  cursor;
  logic [IDX_WIDTH-1:0]  shift_left;
  logic [DATA_WIDTH-1:0] saved;

  logic                  chan_ok;
  logic [CHAN_WIDTH-1:0] chan_sel;
  logic [IDX_WIDTH-1:0]  head_c, tail_c, idx_rel, boq_k, cursor_nxt;
  logic [IDX_WIDTH:0]    count_c;
  logic                  slot_valid, full, empty, fault;
  logic                  do_enlist, do_read, do_write, do_deq, do_boq_zero, do_boq_start, shift_last;

  always_comb begin
    chan_ok    = int'(bus.chan_in) < NUM_CHANNELS;
    chan_sel   = chan_ok ? bus.chan_in : '0;
    head_c     = head[chan_sel];
    tail_c     = tail[chan_sel];
    count_c    = count[chan_sel];
    idx_rel    = bus.idx_in - head_c;
    slot_valid = {1'b0, idx_rel} < count_c;
    full       = count_c == FULL_COUNT;
    empty      = count_c == '0;
    boq_k      = tail_c - IDX_ONE - bus.idx_in;
    cursor_nxt = cursor + IDX_ONE;
    shift_last = (state == ST_SHIFT) && (shift_left == IDX_ONE);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    fault        = 1'b0;
    do_enlist    = 1'b0;
    do_read      = 1'b0;
    do_write     = 1'b0;
    do_deq       = 1'b0;
    do_boq_zero  = 1'b0;
    do_boq_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          if (bus.command != OP_NOP && !chan_ok) begin
            fault = 1'b1;
          end else begin
            case (bus.command)
              OP_NOP:   ;
              OP_ENL:   if (full && !WRAP_EN) fault = 1'b1; else do_enlist = 1'b1;
              OP_READ:  if (slot_valid) do_read = 1'b1; else fault = 1'b1;
              OP_WRITE: if (slot_valid) do_write = 1'b1; else fault = 1'b1;
              OP_DEQ:   if (!empty) do_deq = 1'b1; else fault = 1'b1;
              OP_BOQ: begin
                if (!slot_valid) begin
                  fault = 1'b1;
                end else if (boq_k == '0) begin
                  do_boq_zero = 1'b1;
                end else begin
                  do_boq_start = 1'b1;
                  state_next   = ST_SHIFT;
                end
              end
              default:  fault = 1'b1;
            endcase
          end
          if (fault) state_next = ST_CRASH;
        end
      end
      ST_SHIFT: if (shift_last) state_next = ST_IDLE;
      ST_CRASH: state_next = ST_CRASH;
      default:  state_next = ST_CRASH;
    endcase
    bus.ready     = state == ST_IDLE;
    bus.crashed   = state == ST_CRASH;
    bus.idx_out   = idx_out_r;
    bus.data_out  = data_out_r;
    bus.count_out = count_out_r;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        head[c]  <= '0;
        tail[c]  <= '0;
        count[c] <= '0;
        for (int s = 0; s < DEPTH; s++) mem[c][s] <= '0;
      end
      idx_out_r   <= '0;
      data_out_r  <= '0;
      count_out_r <= '0;
      shift_ch    <= '0;
      cursor      <= '0;
      shift_left  <= '0;
      saved       <= '0;
    end else begin
      if (do_enlist) begin
        mem[chan_sel][tail_c] <= bus.data_in;
        tail[chan_sel]        <= tail_c + IDX_ONE;
        idx_out_r             <= tail_c;
        // a full channel only gets here with wrap enabled: drop the oldest
        if (full) begin
          head[chan_sel] <= head_c + IDX_ONE;
          count_out_r    <= count_c;
        end else begin
          count[chan_sel] <= count_c + CNT_ONE;
          count_out_r     <= count_c + CNT_ONE;
        end
      end
      if (do_read) begin
        data_out_r  <= mem[chan_sel][bus.idx_in];
        idx_out_r   <= bus.idx_in;
        count_out_r <= count_c;
      end
      if (do_write) begin
        mem[chan_sel][bus.idx_in] <= bus.data_in;
        idx_out_r                 <= bus.idx_in;
        count_out_r               <= count_c;
      end
      if (do_deq) begin
        data_out_r            <= mem[chan_sel][head_c];
        idx_out_r             <= head_c;
        mem[chan_sel][head_c] <= '0;
        head[chan_sel]        <= head_c + IDX_ONE;
        count[chan_sel]       <= count_c - CNT_ONE;
        count_out_r           <= count_c - CNT_ONE;
      end
      if (do_boq_zero) begin
        idx_out_r   <= bus.idx_in;
        count_out_r <= count_c;
      end
      if (do_boq_start) begin
        saved      <= mem[chan_sel][bus.idx_in];
        cursor     <= bus.idx_in;
        shift_left <= boq_k;
        shift_ch   <= chan_sel;
      end
      if (state == ST_SHIFT) begin
        mem[shift_ch][cursor] <= mem[shift_ch][cursor_nxt];
        cursor                <= cursor_nxt;
        shift_left            <= shift_left - IDX_ONE;
        // on the last step cursor+1 is tail-1, where the saved entry lands
        if (shift_last) begin
          mem[shift_ch][cursor_nxt] <= saved;
          idx_out_r                 <= cursor_nxt;
          count_out_r               <= count[shift_ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_naughtyq_mc.sv
// Directed bench for naughtyq_mc (IDX_WIDTH=4, DATA_WIDTH=8, NUM_CHANNELS=2).
module tb_naughtyq_mc;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ENL   = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_WRITE = 4'd3;
  localparam logic [3:0] OP_BOQ   = 4'd4;
  localparam logic [3:0] OP_DEQ   = 4'd5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  naughtyq_mc_if #(.IDX_WIDTH(4), .DATA_WIDTH(8), .CHAN_WIDTH(1)) bus ();

  naughtyq_mc #(.IDX_WIDTH(4), .DATA_WIDTH(8), .NUM_CHANNELS(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic ch, input logic [3:0] idx, input logic [7:0] d);
    bus.command = op;
    bus.chan_in = ch;
    bus.idx_in  = idx;
    bus.data_in = d;
    bus.enable  = 1'b1;
    @(posedge clock); #1;
    bus.enable  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.ready !== 1'b1)      begin errors++; $display("FAIL reset_ready got %0b want 1", bus.ready); end
    checks++; if (bus.crashed !== 1'b0)    begin errors++; $display("FAIL reset_crashed got %0b want 0", bus.crashed); end
    checks++; if (bus.idx_out !== 4'd0)    begin errors++; $display("FAIL reset_idx got %0d want 0", bus.idx_out); end
    checks++; if (bus.data_out !== 8'd0)   begin errors++; $display("FAIL reset_data got %0d want 0", bus.data_out); end
    checks++; if (bus.count_out !== 5'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_out); end
  endtask

  task automatic test_enlist_read();
    cmd(OP_ENL, 1'b0, 4'd0, 8'd2);
    checks++; if (bus.idx_out !== 4'd0)   begin errors++; $display("FAIL enl1_idx got %0d want 0", bus.idx_out); end
    checks++; if (bus.count_out !== 5'd1) begin errors++; $display("FAIL enl1_count got %0d want 1", bus.count_out); end
    cmd(OP_ENL, 1'b0, 4'd0, 8'd3);
    checks++; if (bus.idx_out !== 4'd1)   begin errors++; $display("FAIL enl2_idx got %0d want 1", bus.idx_out); end
    checks++; if (bus.count_out !== 5'd2) begin errors++; $display("FAIL enl2_count got %0d want 2", bus.count_out); end
    cmd(OP_READ, 1'b0, 4'd1, 8'd0);
    checks++; if (bus.data_out !== 8'd3)  begin errors++; $display("FAIL read1_data got %0d want 3", bus.data_out); end
  endtask

  task automatic test_isolation();
    cmd(OP_ENL, 1'b1, 4'd0, 8'hAA);
    checks++; if (bus.idx_out !== 4'd0)   begin errors++; $display("FAIL ch1_idx got %0d want 0", bus.idx_out); end
    checks++; if (bus.count_out !== 5'd1) begin errors++; $display("FAIL ch1_count got %0d want 1", bus.count_out); end
    cmd(OP_READ, 1'b0, 4'd0, 8'd0);
    checks++; if (bus.data_out !== 8'd2)  begin errors++; $display("FAIL ch0_data got %0d want 2", bus.data_out); end
    checks++; if (bus.count_out !== 5'd2) begin errors++; $display("FAIL ch0_count got %0d want 2", bus.count_out); end
    cmd(OP_READ, 1'b1, 4'd0, 8'd0);
    checks++; if (bus.data_out !== 8'hAA) begin errors++; $display("FAIL ch1_data got %0h want aa", bus.data_out); end
  endtask

  task automatic test_write();
    cmd(OP_WRITE, 1'b0, 4'd1, 8'h55);
    checks++; if (bus.idx_out !== 4'd1)   begin errors++; $display("FAIL write_idx got %0d want 1", bus.idx_out); end
    cmd(OP_READ, 1'b0, 4'd1, 8'd0);
    checks++; if (bus.data_out !== 8'h55) begin errors++; $display("FAIL write_data got %0h want 55", bus.data_out); end
    cmd(OP_WRITE, 1'b0, 4'd2, 8'h66);
    checks++; if (bus.crashed !== 1'b1)   begin errors++; $display("FAIL write_invalid got %0b want 1", bus.crashed); end
    do_reset();
    cmd(4'd9, 1'b0, 4'd0, 8'd0);
    checks++; if (bus.crashed !== 1'b1)   begin errors++; $display("FAIL illegal_op got %0b want 1", bus.crashed); end
  endtask

  task automatic test_wrap();
    do_reset();
`ifdef NAUGHTYQ_MC_WRAP_EN
    for (int i = 0; i < 20; i++) cmd(OP_ENL, 1'b0, 4'd0, 8'(i));
    checks++; if (bus.idx_out !== 4'd3)    begin errors++; $display("FAIL wrap_idx got %0d want 3", bus.idx_out); end
    checks++; if (bus.count_out !== 5'd16) begin errors++; $display("FAIL wrap_count got %0d want 16", bus.count_out); end
    cmd(OP_READ, 1'b0, 4'd3, 8'd0);
    checks++; if (bus.data_out !== 8'd19)  begin errors++; $display("FAIL wrap_rd3 got %0d want 19", bus.data_out); end
    cmd(OP_READ, 1'b0, 4'd4, 8'd0);
    checks++; if (bus.data_out !== 8'd4)   begin errors++; $display("FAIL wrap_rd4 got %0d want 4", bus.data_out); end
    checks++; if (bus.crashed !== 1'b0)    begin errors++; $display("FAIL wrap_crashed got %0b want 0", bus.crashed); end
`else
    for (int i = 0; i < 16; i++) cmd(OP_ENL, 1'b0, 4'd0, 8'(i));
    checks++; if (bus.crashed !== 1'b0)    begin errors++; $display("FAIL full_crashed got %0b want 0", bus.crashed); end
    checks++; if (bus.count_out !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", bus.count_out); end
    cmd(OP_ENL, 1'b0, 4'd0, 8'd16);
    checks++; if (bus.crashed !== 1'b1)    begin errors++; $display("FAIL ovf_crashed got %0b want 1", bus.crashed); end
    checks++; if (bus.ready !== 1'b0)      begin errors++; $display("FAIL ovf_ready got %0b want 0", bus.ready); end
    checks++; if (bus.idx_out !== 4'd15)   begin errors++; $display("FAIL ovf_idx got %0d want 15", bus.idx_out); end
`endif
  endtask

  task automatic test_back_of_queue();
    int n;
    do_reset();
    // head=4, tail=4, slots 0..3 = 16..19, slots 4..15 = 4..15
    for (int i = 0; i < 16; i++) cmd(OP_ENL, 1'b0, 4'd0, 8'(i));
    for (int i = 0; i < 4; i++) cmd(OP_DEQ, 1'b0, 4'd0, 8'd0);
    for (int i = 16; i < 20; i++) cmd(OP_ENL, 1'b0, 4'd0, 8'(i));
    checks++; if (bus.count_out !== 5'd16) begin errors++; $display("FAIL boq_setup_count got %0d want 16", bus.count_out); end
    cmd(OP_BOQ, 1'b0, 4'd12, 8'd0);
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++; if (n !== 7)                 begin errors++; $display("FAIL boq_busy got %0d want 7", n); end
    checks++; if (bus.idx_out !== 4'd3)    begin errors++; $display("FAIL boq_idx got %0d want 3", bus.idx_out); end
    cmd(OP_READ, 1'b0, 4'd3, 8'd0);
    checks++; if (bus.data_out !== 8'd12)  begin errors++; $display("FAIL boq_rd3 got %0d want 12", bus.data_out); end
    cmd(OP_READ, 1'b0, 4'd12, 8'd0);
    checks++; if (bus.data_out !== 8'd13)  begin errors++; $display("FAIL boq_rd12 got %0d want 13", bus.data_out); end
    cmd(OP_READ, 1'b0, 4'd15, 8'd0);
    checks++; if (bus.data_out !== 8'd16)  begin errors++; $display("FAIL boq_rd15 got %0d want 16", bus.data_out); end
    cmd(OP_READ, 1'b0, 4'd2, 8'd0);
    checks++; if (bus.data_out !== 8'd19)  begin errors++; $display("FAIL boq_rd2 got %0d want 19", bus.data_out); end
    for (int r = 0; r < 2; r++) begin
      cmd(OP_BOQ, 1'b0, 4'd3, 8'd0);
      checks++; if (bus.ready !== 1'b1)    begin errors++; $display("FAIL boq0_ready got %0b want 1", bus.ready); end
      checks++; if (bus.idx_out !== 4'd3)  begin errors++; $display("FAIL boq0_idx got %0d want 3", bus.idx_out); end
    end
    cmd(OP_READ, 1'b0, 4'd3, 8'd0);
    checks++; if (bus.data_out !== 8'd12)  begin errors++; $display("FAIL boq0_rd3 got %0d want 12", bus.data_out); end
    cmd(OP_READ, 1'b0, 4'd2, 8'd0);
    checks++; if (bus.data_out !== 8'd19)  begin errors++; $display("FAIL boq0_rd2 got %0d want 19", bus.data_out); end
    cmd(OP_READ, 1'b1, 4'd0, 8'd0);
    checks++; if (bus.crashed !== 1'b1)    begin errors++; $display("FAIL ch1_untouched got %0b want 1", bus.crashed); end
  endtask

  task automatic test_crash();
    do_reset();
    cmd(OP_READ, 1'b0, 4'd0, 8'd0);
    checks++; if (bus.crashed !== 1'b1)   begin errors++; $display("FAIL crash_flag got %0b want 1", bus.crashed); end
    checks++; if (bus.ready !== 1'b0)     begin errors++; $display("FAIL crash_ready got %0b want 0", bus.ready); end
    cmd(OP_ENL, 1'b0, 4'd0, 8'd7);
    checks++; if (bus.count_out !== 5'd0) begin errors++; $display("FAIL crash_ignore got %0d want 0", bus.count_out); end
    checks++; if (bus.crashed !== 1'b1)   begin errors++; $display("FAIL crash_sticky got %0b want 1", bus.crashed); end
    do_reset();
    checks++; if (bus.crashed !== 1'b0)   begin errors++; $display("FAIL crash_clear got %0b want 0", bus.crashed); end
    checks++; if (bus.ready !== 1'b1)     begin errors++; $display("FAIL crash_ready_back got %0b want 1", bus.ready); end
  endtask

  task automatic test_dequeue();
    do_reset();
    cmd(OP_ENL, 1'b0, 4'd0, 8'd5);
    cmd(OP_ENL, 1'b0, 4'd0, 8'd6);
    cmd(OP_DEQ, 1'b0, 4'd0, 8'd0);
    checks++; if (bus.data_out !== 8'd5)  begin errors++; $display("FAIL deq1_data got %0d want 5", bus.data_out); end
    checks++; if (bus.idx_out !== 4'd0)   begin errors++; $display("FAIL deq1_idx got %0d want 0", bus.idx_out); end
    checks++; if (bus.count_out !== 5'd1) begin errors++; $display("FAIL deq1_count got %0d want 1", bus.count_out); end
    cmd(OP_DEQ, 1'b0, 4'd0, 8'd0);
    checks++; if (bus.data_out !== 8'd6)  begin errors++; $display("FAIL deq2_data got %0d want 6", bus.data_out); end
    checks++; if (bus.idx_out !== 4'd1)   begin errors++; $display("FAIL deq2_idx got %0d want 1", bus.idx_out); end
    checks++; if (bus.count_out !== 5'd0) begin errors++; $display("FAIL deq2_count got %0d want 0", bus.count_out); end
    cmd(OP_DEQ, 1'b0, 4'd0, 8'd0);
    checks++; if (bus.crashed !== 1'b1)   begin errors++; $display("FAIL deq_empty got %0b want 1", bus.crashed); end
  endtask

  initial begin
    bus.command = OP_NOP;
    bus.enable  = 1'b0;
    bus.chan_in = 1'b0;
    bus.idx_in  = 4'd0;
    bus.data_in = 8'd0;
    test_reset();
    test_enlist_read();
    test_isolation();
    test_write();
    test_wrap();
    test_back_of_queue();
    test_crash();
    test_dequeue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end
endmodule
